regfile_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's 2-read/2-write register file.
- Width and depth are configurable, with an optional hardwired zero register and synchronous reset of all storage.
- Adds a per-register pending scoreboard: the issue stage marks a destination pending, and writeback clears it.
- Sits between the decode/issue stage and the two writeback ports. Decode uses the busy outputs to stall on RAW hazards the bypass cannot cover.

---
 rtl/regfile_scoreboard_pkg.sv | 5 +
 rtl/regfile_scoreboard_if.sv | 37 +++
 rtl/regfile_scoreboard_rf_scoreboard.sv | 62 ++++++
 rtl/regfile_scoreboard.sv | 77 +++++++
 tb/tb_regfile_scoreboard.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file with pending-write scoreboard.
package regfile_scoreboard_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Register-file bundle: two write ports, two read ports, issue/flush and hazard status.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic             we3;
  logic [AW-1:0]    wa3;
  logic [WIDTH-1:0] wd3;
  logic             we4;
  logic [AW-1:0]    wa4;
  logic [WIDTH-1:0] wd4;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic             busy1;
  logic             busy2;
  logic [CW-1:0]    pend_cnt;

  modport master (
    output we3, wa3, wd3, we4, wa4, wd4, ra1, ra2, iss_en, iss_addr, flush,
    input  rd1, rd2, busy1, busy2, pend_cnt
  );

  modport slave (
    input  we3, wa3, wd3, we4, wa4, wd4, ra1, ra2, iss_en, iss_addr, flush,
    output rd1, rd2, busy1, busy2, pend_cnt
  );
endinterface

// File: rtl/regfile_scoreboard_rf_scoreboard.sv
// Pending-destination scoreboard: pending vector, registered pending count, busy lookups.
module rf_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic          we4,
  input  logic [AW-1:0] wa4,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  input  logic          flush,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2,
  output logic [CW-1:0] pend_cnt
);
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic             iss_ok;
  logic             inc;
  logic             clr3;
  logic             clr4;

  always_comb begin
    iss_ok = iss_en && !(ZERO_REG && iss_addr == '0);
    inc    = iss_ok && !pending[iss_addr];
    // A re-issued destination stays pending, so a writeback to it is not a clear.
    clr3   = we3 && pending[wa3] && !(iss_ok && iss_addr == wa3);
    // Dual write to one address is counted once, via port 3.
    clr4   = we4 && !(we3 && wa3 == wa4) && pending[wa4] && !(iss_ok && iss_addr == wa4);

    pending_nxt = pending;
    if (we3)    pending_nxt[wa3]      = 1'b0;
    if (we4)    pending_nxt[wa4]      = 1'b0;
    if (iss_ok) pending_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= pend_cnt + CW'(inc) - CW'(clr3) - CW'(clr4);
    end
  end

  always_comb begin
    busy1 = !reset && pending[ra1] && !(we3 && wa3 == ra1) && !(we4 && wa4 == ra1)
            && !(ZERO_REG && ra1 == '0);
    busy2 = !reset && pending[ra2] && !(we3 && wa3 == ra2) && !(we4 && wa4 == ra2)
            && !(ZERO_REG && ra2 == '0);
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// 2-read/2-write register file with write-through bypass and a pending scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter bit ZERO_REG = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             w3_ok;
  logic             w4_ok;

  function automatic logic [WIDTH-1:0] read_port(
    input logic [AW-1:0]    ra,
    input logic             rst,
    input logic             we3,
    input logic [AW-1:0]    wa3,
    input logic [WIDTH-1:0] wd3,
    input logic             we4,
    input logic [AW-1:0]    wa4,
    input logic [WIDTH-1:0] wd4,
    input logic [WIDTH-1:0] stored
  );
    if (rst || (ZERO_REG && ra == '0)) return '0;
    if (we3 && wa3 == ra)              return wd3;
    if (we4 && wa4 == ra)              return wd4;
    return stored;
  endfunction

  always_comb begin
    w3_ok = bus.we3 && !(ZERO_REG && bus.wa3 == '0);
    w4_ok = bus.we4 && !(ZERO_REG && bus.wa4 == '0);
  end

  // Port 3 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (w4_ok) mem[bus.wa4] <= bus.wd4;
      if (w3_ok) mem[bus.wa3] <= bus.wd3;
    end
  end

  always_comb begin
    bus.rd1 = read_port(bus.ra1, reset, bus.we3, bus.wa3, bus.wd3,
                        bus.we4, bus.wa4, bus.wd4, mem[bus.ra1]);
    bus.rd2 = read_port(bus.ra2, reset, bus.we3, bus.wa3, bus.wd3,
                        bus.we4, bus.wa4, bus.wd4, mem[bus.ra2]);
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .we3      (bus.we3),
    .wa3      (bus.wa3),
    .we4      (bus.we4),
    .wa4      (bus.wa4),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .flush    (bus.flush),
    .ra1      (bus.ra1),
    .ra2      (bus.ra2),
    .busy1    (bus.busy1),
    .busy2    (bus.busy2),
    .pend_cnt (bus.pend_cnt)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: ZERO_REG=0 and ZERO_REG=1 instances on shared stimulus.
module tb_regfile_scoreboard;
  localparam int W = 8;
  localparam int D = 8;

  typedef struct packed {
    logic       reset;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic       we4;
    logic [2:0] wa4;
    logic [7:0] wd4;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic       iss_en;
    logic [2:0] iss_addr;
    logic       flush;
  } stim_t;

  typedef struct packed {
    logic [1:0][7:0] rd1;
    logic [1:0][7:0] rd2;
    logic [1:0]      b1;
    logic [1:0]      b2;
    logic [1:0][3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  regfile_scoreboard_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

  regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b0)) u_dut0 (
    .clk (clk), .reset (reset), .bus (bus0)
  );
  regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1)) u_dut1 (
    .clk (clk), .reset (reset), .bus (bus1)
  );

  // Reference state: index 0 models ZERO_REG=0, index 1 models ZERO_REG=1.
  logic [7:0] mmem  [2][8];
  bit         mpend [2][8];
  exp_t       expq [$];
  int         n_total = 0;
  int         n_pass  = 0;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endfunction

  function automatic logic [7:0] mread(int z, logic [2:0] ra, stim_t s);
    if (s.reset || (z == 1 && ra == 3'd0)) return 8'h00;
    if (s.we3 && s.wa3 == ra) return s.wd3;
    if (s.we4 && s.wa4 == ra) return s.wd4;
    return mmem[z][ra];
  endfunction

  function automatic logic mbusy(int z, logic [2:0] ra, stim_t s);
    if (s.reset || (z == 1 && ra == 3'd0)) return 1'b0;
    return mpend[z][ra] && !(s.we3 && s.wa3 == ra) && !(s.we4 && s.wa4 == ra);
  endfunction

  function automatic logic [3:0] mcount(int z);
    int n = 0;
    foreach (mpend[z][i]) n += int'(mpend[z][i]);
    return 4'(n);
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = s.reset;
    bus0.we3      = s.we3;      bus1.we3      = s.we3;
    bus0.wa3      = s.wa3;      bus1.wa3      = s.wa3;
    bus0.wd3      = s.wd3;      bus1.wd3      = s.wd3;
    bus0.we4      = s.we4;      bus1.we4      = s.we4;
    bus0.wa4      = s.wa4;      bus1.wa4      = s.wa4;
    bus0.wd4      = s.wd4;      bus1.wd4      = s.wd4;
    bus0.ra1      = s.ra1;      bus1.ra1      = s.ra1;
    bus0.ra2      = s.ra2;      bus1.ra2      = s.ra2;
    bus0.iss_en   = s.iss_en;   bus1.iss_en   = s.iss_en;
    bus0.iss_addr = s.iss_addr; bus1.iss_addr = s.iss_addr;
    bus0.flush    = s.flush;    bus1.flush    = s.flush;
    for (int z = 0; z < 2; z++) begin
      e.rd1[z] = mread(z, s.ra1, s);
      e.rd2[z] = mread(z, s.ra2, s);
      e.b1[z]  = mbusy(z, s.ra1, s);
      e.b2[z]  = mbusy(z, s.ra2, s);
      e.cnt[z] = mcount(z);
    end
    expq.push_back(e);
    // Advance the model to the state after the coming edge.
    for (int z = 0; z < 2; z++) begin
      if (s.reset) begin
        foreach (mmem[z][i]) begin mmem[z][i] = 8'h00; mpend[z][i] = 1'b0; end
      end else begin
        if (s.we4 && !(z == 1 && s.wa4 == 3'd0)) mmem[z][s.wa4] = s.wd4;
        if (s.we3 && !(z == 1 && s.wa3 == 3'd0)) mmem[z][s.wa3] = s.wd3;
        if (s.flush) begin
          foreach (mpend[z][i]) mpend[z][i] = 1'b0;
        end else begin
          if (s.we3) mpend[z][s.wa3] = 1'b0;
          if (s.we4) mpend[z][s.wa4] = 1'b0;
          if (s.iss_en && !(z == 1 && s.iss_addr == 3'd0)) mpend[z][s.iss_addr] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("rd1_z0",   bus0.rd1,             e.rd1[0]);
      chk("rd2_z0",   bus0.rd2,             e.rd2[0]);
      chk("busy1_z0", {7'd0, bus0.busy1},   {7'd0, e.b1[0]});
      chk("busy2_z0", {7'd0, bus0.busy2},   {7'd0, e.b2[0]});
      chk("cnt_z0",   {4'd0, bus0.pend_cnt}, {4'd0, e.cnt[0]});
      chk("rd1_z1",   bus1.rd1,             e.rd1[1]);
      chk("rd2_z1",   bus1.rd2,             e.rd2[1]);
      chk("busy1_z1", {7'd0, bus1.busy1},   {7'd0, e.b1[1]});
      chk("busy2_z1", {7'd0, bus1.busy2},   {7'd0, e.b2[1]});
      chk("cnt_z1",   {4'd0, bus1.pend_cnt}, {4'd0, e.cnt[1]});
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    foreach (mmem[z, i]) begin mmem[z][i] = 8'h00; mpend[z][i] = 1'b0; end

    s = '0; s.reset = 1'b1; apply(s);
    // Write r3 then reset: stored value must be gone.
    s = '0; s.we3 = 1'b1; s.wa3 = 3'd3; s.wd3 = 8'h55; s.ra1 = 3'd3; apply(s);
    s = '0; s.reset = 1'b1; s.ra1 = 3'd3; apply(s);
    s = '0; s.ra1 = 3'd3; apply(s);
    // Bypass priority and dual-write collision.
    s = '0; s.we3 = 1'b1; s.we4 = 1'b1; s.wa3 = 3'd5; s.wa4 = 3'd5;
    s.wd3 = 8'hAA; s.wd4 = 8'h11; s.ra1 = 3'd5; apply(s);
    s = '0; s.ra1 = 3'd5; apply(s);
    // Issue then writeback.
    s = '0; s.iss_en = 1'b1; s.iss_addr = 3'd2; s.ra1 = 3'd2; apply(s);
    s = '0; s.ra1 = 3'd2; apply(s);
    s = '0; s.we4 = 1'b1; s.wa4 = 3'd2; s.wd4 = 8'h3C; s.ra1 = 3'd2; apply(s);
    s = '0; s.ra1 = 3'd2; apply(s);
    // Issue vs writeback collision.
    s = '0; s.iss_en = 1'b1; s.iss_addr = 3'd6; apply(s);
    s = '0; s.iss_en = 1'b1; s.iss_addr = 3'd6; s.we3 = 1'b1; s.wa3 = 3'd6;
    s.wd3 = 8'h77; s.ra1 = 3'd6; apply(s);
    s = '0; s.ra1 = 3'd6; apply(s);
    // Flush with a concurrent issue.
    s = '0; s.iss_en = 1'b1; s.iss_addr = 3'd1; apply(s);
    s = '0; s.iss_en = 1'b1; s.iss_addr = 3'd4; apply(s);
    s = '0; s.iss_en = 1'b1; s.iss_addr = 3'd7; s.ra1 = 3'd1; s.ra2 = 3'd4; apply(s);
    s = '0; s.flush = 1'b1; s.iss_en = 1'b1; s.iss_addr = 3'd2; s.ra1 = 3'd1; s.ra2 = 3'd7; apply(s);
    s = '0; s.ra1 = 3'd2; s.ra2 = 3'd7; apply(s);
    // Writes and issues to r0.
    s = '0; s.we3 = 1'b1; s.wa3 = 3'd0; s.wd3 = 8'hFF; s.iss_en = 1'b1;
    s.iss_addr = 3'd0; s.ra1 = 3'd0; apply(s);
    s = '0; s.ra1 = 3'd0; apply(s);

    for (int n = 0; n < 600; n++) begin
      s          = '0;
      s.reset    = ($urandom_range(0, 63) == 0);
      s.flush    = ($urandom_range(0, 15) == 0);
      s.we3      = 1'($urandom_range(0, 1));
      s.wa3      = 3'($urandom_range(0, 7));
      s.wd3      = 8'($urandom);
      s.we4      = 1'($urandom_range(0, 1));
      s.wa4      = 3'($urandom_range(0, 7));
      s.wd4      = 8'($urandom);
      s.ra1      = 3'($urandom_range(0, 7));
      s.ra2      = 3'($urandom_range(0, 7));
      s.iss_en   = 1'($urandom_range(0, 1));
      s.iss_addr = 3'($urandom_range(0, 7));
      apply(s);
    end

    s = '0; apply(s);
    repeat (3) @(posedge clk);
    chk("drain", 8'(expq.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
